// File: rtl/if_prefetch_unit_pkg.sv
// Shared CPU definitions: reset PC default, fetch FSM encoding, NOP word.
package if_prefetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Parametric synchronous FIFO with a flush that takes priority over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking with reset/flush priority.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: credit-limited fetch into a small queue, with
// redirect flush and drop counting of responses still in flight.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | one cycle after reset before fetching starts
//   ST_RUN   | issuing requests and queueing responses
//   ST_FLUSH | discarding stale responses left over from a redirect
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_q_count;
    logic          w_q_empty;
    logic [63:0]   w_q_head;
    logic [31:0]   w_pc_head;
    logic [CW:0]   w_credit_sum;
    logic          w_req_hs;
    logic          w_resp_keep;
    logic          w_out_pop;
    logic [CW-1:0] w_drop_load;
    logic [CW-1:0] w_flush_dec;
    logic [CW-1:0] w_unused_pc_count;
    logic          w_unused_pc_empty;
    logic          w_unused_pc_bits;

    assign w_unused_pc_bits = ^redirect_pc[1:0];

    // Queue entries plus requests in flight may never exceed DEPTH, so a
    // response always finds room in the queue.
    assign w_credit_sum   = {1'b0, w_q_count} + {1'b0, r_inflight};
    assign imem_req_valid = (r_state == ST_RUN) && !redirect &&
                            (w_credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    // Only responses arriving in RUN outside a redirect cycle are live.
    assign w_resp_keep = imem_resp_valid && (r_state == ST_RUN) && !redirect;
    assign w_out_pop   = out_valid && out_ready && !redirect;
    assign w_drop_load = r_inflight - CW'(imem_resp_valid);
    assign w_flush_dec = CW'(imem_resp_valid && (r_drop != '0));

    assign out_valid       = !w_q_empty;
    assign out_pc          = w_q_empty ? 32'h0 : w_q_head[63:32];
    assign out_instruction = w_q_empty ? 32'h0 : w_q_head[31:0];

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_req_hs),
        .i_data  (r_fetch_pc),
        .i_pop   (w_resp_keep),
        .o_data  (w_pc_head),
        .o_empty (w_unused_pc_empty),
        .o_count (w_unused_pc_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_resp_keep),
        .i_data  ({w_pc_head, imem_resp_data}),
        .i_pop   (w_out_pop),
        .o_data  (w_q_head),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Fetch FSM: fetch PC, in-flight credit and stale-response drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (redirect) r_fetch_pc <= word_align(redirect_pc);
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        r_fetch_pc <= word_align(redirect_pc);
                        r_drop     <= w_drop_load;
                        r_inflight <= w_drop_load;
                        if (r_inflight != '0) r_state <= ST_FLUSH;
                    end else begin
                        if (w_req_hs) r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_inflight <= r_inflight + CW'(w_req_hs) - CW'(imem_resp_valid);
                    end
                end
                ST_FLUSH: begin
                    // A second redirect only retargets; stale count stands.
                    if (redirect) r_fetch_pc <= word_align(redirect_pc);
                    r_drop     <= r_drop - w_flush_dec;
                    r_inflight <= r_inflight - w_flush_dec;
                    if ((r_drop - w_flush_dec) == '0) r_state <= ST_RUN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, sets the instruction queue depth and the outstanding-request limit; legal values are 2..8.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 redirect  in  1  branch-taken redirect, driven from the MEM-stage PCSrc.
REQ-006 redirect_pc  in  32  redirect target; bits [1:0] are ignored.
REQ-007 imem_req_valid  out  1  instruction-memory request valid.
REQ-008 imem_req_addr  out  32  request word address, with bits [1:0] always 0.
REQ-009 imem_req_ready  in  1  memory accepts the request.
REQ-010 imem_resp_valid  in  1  read data valid; responses are in order with latency of at least 1 cycle.
REQ-011 imem_resp_data  in  32  instruction word.
REQ-012 out_valid  out  1  instruction available to the IF/ID register.
REQ-013 out_pc  out  32  PC of the presented instruction.
REQ-014 out_instruction  out  32  the presented instruction.
REQ-015 out_ready  in  1  IF/ID consumes the instruction; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-016 The FSM states SHALL be IDLE, RUN and FLUSH: IDLE->RUN unconditionally; RUN->FLUSH on redirect while in-flight>0; RUN stays RUN on redirect when in-flight=0; FLUSH->RUN when the drop count reaches 0.
REQ-017 imem_req_valid SHALL be high only in RUN, with redirect low and (queue count + in-flight) < DEPTH.
REQ-018 On a request handshake, fetch_pc SHALL advance by 4 (modulo 2^32, with FFFF_FFFC wrapping to 0) and in-flight SHALL increment.
REQ-019 A non-dropped response SHALL push {pc, data} into the queue; the queue PC comes from a per-request PC FIFO of depth DEPTH.
REQ-020 out_valid SHALL equal queue-not-empty; outputs SHALL come from the queue head only, with no response-to-output bypass; latency from response to out_valid is 1 cycle.
REQ-021 Request and response in the same cycle SHALL leave in-flight unchanged, and push and pop in the same cycle SHALL leave the count unchanged; a push into a full queue cannot occur by the credit rule.
REQ-022 On redirect: the queue SHALL be flushed; fetch_pc SHALL be set to {redirect_pc[31:2],2'b00}; drop count SHALL be set to in-flight minus (imem_resp_valid ? 1 : 0); in-flight SHALL be set to the drop count; the response in the redirect cycle SHALL be discarded.
REQ-023 Redirect SHALL take priority over a simultaneous out handshake, so out_valid is 0 in the next cycle.
REQ-024 In FLUSH, each response SHALL decrement the drop count and in-flight and be discarded; no requests are issued.
REQ-025 A redirect received during FLUSH SHALL update fetch_pc only and leave the drop count as-is.
REQ-026 The first request SHALL go out the cycle after IDLE, at address RESET_PC.

Reset
REQ-027 While rst is high: state=IDLE, fetch_pc=RESET_PC, queue, in-flight and drop count = 0; imem_req_valid=0, out_valid=0, out_pc=0, out_instruction=0.
REQ-028 rst asserted mid-operation SHALL abandon all in-flight requests; the environment resets memory in the same cycle.

Structure
REQ-029 RESET_PC default, the state encoding enum, and the NOP constant 32'h0000_0013 SHALL live in the shared cpu package.
REQ-030 One sub-module, fetch_fifo (parametric width/depth, synchronous flush), SHALL be instantiated twice: for the instruction queue and for the PC FIFO.

Verification
REQ-031 Reset release, memory latency 1, out_ready=1 -> requests at 0,4,8; out_pc sequence 0,4,8 with matching data; first out_valid 3 cycles after reset release.
REQ-032 out_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0; out_valid held with out_pc=0.
REQ-033 Latency 3, redirect to 32'h0000_0103 with 2 in flight -> both stale responses dropped; next request address 0x100; next out_pc=0x100.
REQ-034 Redirect in the same cycle as an out handshake and a response -> no stale instruction appears; drop count=in-flight-1.
REQ-035 fetch_pc=FFFF_FFFC -> next request address 0000_0000.
REQ-036 rst asserted during FLUSH -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
